decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 52 +++++
 rtl/decode_stage.sv | 199 +++++++++++++++++++
 tb/tb_decode_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the fetch-side handshake, the decoded-entry bus
// toward the ALU/register file, and the halt control of decode_stage.
//
//   instr / instr_valid / instr_ready   fetch handshake (ready driven by slave)
//   out_valid / out_ready               decoded-entry handshake (valid by slave)
//   *_en, sign_valid, imm_valid, imm    decoded ALU control and immediate
//   rs1_addr, rs2_addr, rd_addr         register-file addresses
//   illegal, halted                     held-entry status and stage status
//   clear_halt                          pulse from master that leaves HALT
//
// master: the environment (fetch + execute side); slave: decode_stage.
interface decode_stage_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        out_ready;
    logic        out_valid;
    logic        add_en;
    logic        sub_en;
    logic        sll_en;
    logic        slt_en;
    logic        xor_en;
    logic        sra_en;
    logic        srl_en;
    logic        or_en;
    logic        and_en;
    logic        sign_valid;
    logic        imm_valid;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        illegal;
    logic        halted;
    logic        clear_halt;

    modport master (
        output instr, instr_valid, out_ready, clear_halt,
        input  instr_ready, out_valid,
        input  add_en, sub_en, sll_en, slt_en, xor_en, sra_en, srl_en, or_en, and_en,
        input  sign_valid, imm_valid, imm, rs1_addr, rs2_addr, rd_addr,
        input  illegal, halted
    );

    modport slave (
        input  instr, instr_valid, out_ready, clear_halt,
        output instr_ready, out_valid,
        output add_en, sub_en, sll_en, slt_en, xor_en, sra_en, srl_en, or_en, and_en,
        output sign_valid, imm_valid, imm, rs1_addr, rs2_addr, rd_addr,
        output illegal, halted
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: one-entry RV32I OP / OP-IMM decoder with a valid/ready
// output register. An accepted word is decoded combinationally and captured
// into the output register on the same edge (1-cycle latency). Accept and
// drain in the same cycle replace the entry without a bubble. Accepting an
// unsupported encoding parks the stage in HALT until clear_halt.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    decode_stage_if.slave (fetch handshake, decoded entry, halt control)
//
// States:
//   state | meaning
//   RUN   | accepting words whenever the output register is free or draining
//   HALT  | an illegal word was accepted; no new words until clear_halt
module decode_stage (
    input  logic             clk,
    input  logic             rst_n,
    decode_stage_if.slave    bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    // Enable vector bit order: add sub sll slt xor sra srl or and
    localparam logic [8:0] EN_ADD = 9'b1_0000_0000;
    localparam logic [8:0] EN_SUB = 9'b0_1000_0000;
    localparam logic [8:0] EN_SLL = 9'b0_0100_0000;
    localparam logic [8:0] EN_SLT = 9'b0_0010_0000;
    localparam logic [8:0] EN_XOR = 9'b0_0001_0000;
    localparam logic [8:0] EN_SRA = 9'b0_0000_1000;
    localparam logic [8:0] EN_SRL = 9'b0_0000_0100;
    localparam logic [8:0] EN_OR  = 9'b0_0000_0010;
    localparam logic [8:0] EN_AND = 9'b0_0000_0001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    state_t      state;
    logic        out_valid_q;
    logic [8:0]  en_q;
    logic        sign_q;
    logic        imm_valid_q;
    logic [31:0] imm_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic        illegal_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        instr_ready;
    logic        accept;
    logic        drain;

    logic [8:0]  dec_en;
    logic        dec_sign;
    logic        dec_imm_valid;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];

    assign instr_ready = (state == RUN) && (!out_valid_q || bus.out_ready);
    assign accept      = bus.instr_valid && instr_ready;
    assign drain       = out_valid_q && bus.out_ready;

    // funct3 mapping shared by OP and OP-IMM when funct7 carries no alternate
    function automatic logic [8:0] f3_onehot(input logic [2:0] f3);
        logic [8:0] en;
        case (f3)
            3'b000:  en = EN_ADD;
            3'b001:  en = EN_SLL;
            3'b010:  en = EN_SLT;
            3'b011:  en = EN_SLT;
            3'b100:  en = EN_XOR;
            3'b101:  en = EN_SRL;
            3'b110:  en = EN_OR;
            default: en = EN_AND;
        endcase
        return en;
    endfunction

    always_comb begin
        dec_en        = '0;
        dec_imm_valid = 1'b0;
        dec_imm       = '0;
        dec_illegal   = 1'b0;

        if (opcode == OPC_OP) begin
            if (funct7 == F7_BASE) begin
                dec_en = f3_onehot(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                dec_en = EN_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                dec_en = EN_SRA;
            end else begin
                dec_illegal = 1'b1;
            end
        end else if (opcode == OPC_OP_IMM) begin
            dec_imm_valid = 1'b1;
            if (funct3 == 3'b001) begin
                // slli: upper seven bits must be zero
                dec_imm = {27'b0, bus.instr[24:20]};
                if (funct7 == F7_BASE) dec_en = EN_SLL;
                else                   dec_illegal = 1'b1;
            end else if (funct3 == 3'b101) begin
                // srli/srai: upper seven bits pick the shift flavour
                dec_imm = {27'b0, bus.instr[24:20]};
                if (funct7 == F7_BASE)     dec_en = EN_SRL;
                else if (funct7 == F7_ALT) dec_en = EN_SRA;
                else                       dec_illegal = 1'b1;
            end else begin
                dec_imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
                dec_en  = f3_onehot(funct3);
            end
        end else begin
            dec_illegal = 1'b1;
        end

        if (dec_illegal) begin
            dec_en        = '0;
            dec_imm_valid = 1'b0;
            dec_imm       = '0;
        end

        // Only sltu/sltiu are unsigned; every other entry reports signed
        dec_sign = !(!dec_illegal && funct3 == 3'b011);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            out_valid_q <= 1'b0;
            en_q        <= '0;
            sign_q      <= 1'b0;
            imm_valid_q <= 1'b0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                en_q        <= dec_en;
                sign_q      <= dec_sign;
                imm_valid_q <= dec_imm_valid;
                imm_q       <= dec_imm;
                rs1_q       <= bus.instr[19:15];
                rs2_q       <= bus.instr[24:20];
                rd_q        <= bus.instr[11:7];
                illegal_q   <= dec_illegal;
            end else if (drain) begin
                // An empty register must not advertise an operation
                out_valid_q <= 1'b0;
                en_q        <= '0;
                imm_valid_q <= 1'b0;
                illegal_q   <= 1'b0;
            end

            // clear_halt is only examined in HALT, so a pulse that lands on
            // the HALT-entering accept is lost and HALT wins.
            case (state)
                RUN:     if (accept && dec_illegal) state <= HALT;
                HALT:    if (bus.clear_halt)        state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.add_en      = en_q[8];
    assign bus.sub_en      = en_q[7];
    assign bus.sll_en      = en_q[6];
    assign bus.slt_en      = en_q[5];
    assign bus.xor_en      = en_q[4];
    assign bus.sra_en      = en_q[3];
    assign bus.srl_en      = en_q[2];
    assign bus.or_en       = en_q[1];
    assign bus.and_en      = en_q[0];
    assign bus.sign_valid  = sign_q;
    assign bus.imm_valid   = imm_valid_q;
    assign bus.imm         = imm_q;
    assign bus.rs1_addr    = rs1_q;
    assign bus.rs2_addr    = rs2_q;
    assign bus.rd_addr     = rd_q;
    assign bus.illegal     = illegal_q;
    assign bus.halted      = (state == HALT);

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    decode_stage_if bus();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    localparam logic [8:0] E_NONE = 9'b0_0000_0000;
    localparam logic [8:0] E_ADD  = 9'b1_0000_0000;
    localparam logic [8:0] E_SUB  = 9'b0_1000_0000;
    localparam logic [8:0] E_SLL  = 9'b0_0100_0000;
    localparam logic [8:0] E_SLT  = 9'b0_0010_0000;
    localparam logic [8:0] E_XOR  = 9'b0_0001_0000;
    localparam logic [8:0] E_SRA  = 9'b0_0000_1000;
    localparam logic [8:0] E_SRL  = 9'b0_0000_0100;
    localparam logic [8:0] E_OR   = 9'b0_0000_0010;
    localparam logic [8:0] E_AND  = 9'b0_0000_0001;

    typedef struct {
        logic [31:0] instr;
        logic [8:0]  en;
        logic        sign;
        logic        imm_valid;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] bad[$];

    function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_enc(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [8:0] en_now();
        return {bus.add_en, bus.sub_en, bus.sll_en, bus.slt_en, bus.xor_en,
                bus.sra_en, bus.srl_en, bus.or_en, bus.and_en};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_word(input logic [31:0] w);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr       = '0;
        bus.instr_valid = 1'b0;
        bus.out_ready   = 1'b0;
        bus.clear_halt  = 1'b0;

        vecs.push_back(vec_t'{32'hFFF30293, E_ADD, 1'b1, 1'b1, 32'hFFFFFFFF, 5'd6, 5'd31, 5'd5});
        vecs.push_back(vec_t'{32'h402081B3, E_SUB, 1'b1, 1'b0, 32'h0, 5'd1, 5'd2, 5'd3});
        vecs.push_back(vec_t'{32'h41F0D093, E_SRA, 1'b1, 1'b1, 32'd31, 5'd1, 5'd31, 5'd1});
        vecs.push_back(vec_t'{32'h00503113, E_SLT, 1'b0, 1'b1, 32'd5, 5'd0, 5'd5, 5'd2});
        vecs.push_back(vec_t'{r_enc(7'h00, 5'd9, 5'd8, 3'b111, 5'd7), E_AND, 1'b1, 1'b0, 32'h0, 5'd8, 5'd9, 5'd7});
        vecs.push_back(vec_t'{r_enc(7'h00, 5'd12, 5'd11, 3'b110, 5'd10), E_OR, 1'b1, 1'b0, 32'h0, 5'd11, 5'd12, 5'd10});
        vecs.push_back(vec_t'{r_enc(7'h00, 5'd14, 5'd13, 3'b100, 5'd15), E_XOR, 1'b1, 1'b0, 32'h0, 5'd13, 5'd14, 5'd15});
        vecs.push_back(vec_t'{r_enc(7'h00, 5'd17, 5'd16, 3'b001, 5'd18), E_SLL, 1'b1, 1'b0, 32'h0, 5'd16, 5'd17, 5'd18});
        vecs.push_back(vec_t'{r_enc(7'h00, 5'd20, 5'd19, 3'b011, 5'd21), E_SLT, 1'b0, 1'b0, 32'h0, 5'd19, 5'd20, 5'd21});
        vecs.push_back(vec_t'{r_enc(7'h00, 5'd23, 5'd22, 3'b010, 5'd24), E_SLT, 1'b1, 1'b0, 32'h0, 5'd22, 5'd23, 5'd24});
        vecs.push_back(vec_t'{r_enc(7'h00, 5'd26, 5'd25, 3'b101, 5'd27), E_SRL, 1'b1, 1'b0, 32'h0, 5'd25, 5'd26, 5'd27});
        vecs.push_back(vec_t'{r_enc(7'h20, 5'd5, 5'd4, 3'b101, 5'd3), E_SRA, 1'b1, 1'b0, 32'h0, 5'd4, 5'd5, 5'd3});
        vecs.push_back(vec_t'{r_enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd0), E_ADD, 1'b1, 1'b0, 32'h0, 5'd0, 5'd0, 5'd0});
        vecs.push_back(vec_t'{i_enc({7'h00, 5'd7}, 5'd5, 3'b001, 5'd4), E_SLL, 1'b1, 1'b1, 32'd7, 5'd5, 5'd7, 5'd4});
        vecs.push_back(vec_t'{i_enc({7'h00, 5'd19}, 5'd2, 3'b101, 5'd30), E_SRL, 1'b1, 1'b1, 32'd19, 5'd2, 5'd19, 5'd30});
        vecs.push_back(vec_t'{i_enc(12'h7FF, 5'd2, 3'b100, 5'd1), E_XOR, 1'b1, 1'b1, 32'h000007FF, 5'd2, 5'd31, 5'd1});
        vecs.push_back(vec_t'{i_enc(12'h800, 5'd3, 3'b111, 5'd9), E_AND, 1'b1, 1'b1, 32'hFFFFF800, 5'd3, 5'd0, 5'd9});
        vecs.push_back(vec_t'{i_enc(12'h123, 5'd31, 3'b110, 5'd31), E_OR, 1'b1, 1'b1, 32'h00000123, 5'd31, 5'd3, 5'd31});
        vecs.push_back(vec_t'{i_enc(12'hFFE, 5'd4, 3'b010, 5'd6), E_SLT, 1'b1, 1'b1, 32'hFFFFFFFE, 5'd4, 5'd30, 5'd6});

        bad.push_back(32'h0000006F);                                    // jal
        bad.push_back(r_enc(7'h01, 5'd2, 5'd1, 3'b000, 5'd3));          // mul
        bad.push_back(r_enc(7'h20, 5'd2, 5'd1, 3'b001, 5'd3));          // alt funct7 on sll
        bad.push_back(i_enc({7'h20, 5'd3}, 5'd1, 3'b001, 5'd2));        // slli with alt funct7
        bad.push_back(i_enc({7'h01, 5'd3}, 5'd1, 3'b101, 5'd2));        // bad shift funct7
        bad.push_back(32'h000120B7);                                    // lui

        // Reset values, with an illegal word offered across an edge in reset
        #2;
        chk("rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst enables", 32'(en_now()), 32'(E_NONE));
        chk("rst sign_valid", 32'(bus.sign_valid), 32'h0);
        chk("rst imm_valid", 32'(bus.imm_valid), 32'h0);
        chk("rst imm", bus.imm, 32'h0);
        chk("rst addrs", 32'({bus.rs1_addr, bus.rs2_addr, bus.rd_addr}), 32'h0);
        chk("rst illegal", 32'(bus.illegal), 32'h0);
        chk("rst halted", 32'(bus.halted), 32'h0);
        bus.instr       = 32'h0000006F;
        bus.instr_valid = 1'b1;
        tick();
        chk("rst no accept out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst no accept halted", 32'(bus.halted), 32'h0);
        bus.instr_valid = 1'b0;
        #4 rst_n = 1'b1;
        tick();

        // Legal decode table, back to back with out_ready held high
        bus.out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            accept_word(v.instr);
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'h1);
            chk($sformatf("vec%0d enables", i), 32'(en_now()), 32'(v.en));
            chk($sformatf("vec%0d sign_valid", i), 32'(bus.sign_valid), 32'(v.sign));
            chk($sformatf("vec%0d imm_valid", i), 32'(bus.imm_valid), 32'(v.imm_valid));
            chk($sformatf("vec%0d imm", i), bus.imm, v.imm);
            chk($sformatf("vec%0d rs1", i), 32'(bus.rs1_addr), 32'(v.rs1));
            chk($sformatf("vec%0d rs2", i), 32'(bus.rs2_addr), 32'(v.rs2));
            chk($sformatf("vec%0d rd", i), 32'(bus.rd_addr), 32'(v.rd));
            chk($sformatf("vec%0d illegal", i), 32'(bus.illegal), 32'h0);
            chk($sformatf("vec%0d halted", i), 32'(bus.halted), 32'h0);
        end
        tick();
        chk("drain out_valid", 32'(bus.out_valid), 32'h0);
        chk("drain enables", 32'(en_now()), 32'(E_NONE));
        chk("drain imm_valid", 32'(bus.imm_valid), 32'h0);

        // Stall for three cycles, then back-to-back replace
        bus.out_ready = 1'b0;
        accept_word(r_enc(7'h00, 5'd3, 5'd2, 3'b000, 5'd1));
        bus.instr       = 32'h402081B3;
        bus.instr_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d instr_ready", c), 32'(bus.instr_ready), 32'h0);
            chk($sformatf("stall%0d out_valid", c), 32'(bus.out_valid), 32'h1);
            chk($sformatf("stall%0d enables", c), 32'(en_now()), 32'(E_ADD));
            chk($sformatf("stall%0d addrs", c), 32'({bus.rs1_addr, bus.rs2_addr, bus.rd_addr}),
                32'({5'd2, 5'd3, 5'd1}));
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("replace instr_ready", 32'(bus.instr_ready), 32'h1);
        tick();
        bus.instr_valid = 1'b0;
        chk("replace out_valid", 32'(bus.out_valid), 32'h1);
        chk("replace enables", 32'(en_now()), 32'(E_SUB));
        chk("replace rd", 32'(bus.rd_addr), 32'd3);
        tick();
        chk("replace drain", 32'(bus.out_valid), 32'h0);

        // Illegal words: halt, held entry drains in HALT, clear_halt resumes
        for (int i = 0; i < bad.size(); i++) begin
            bus.out_ready = 1'b0;
            accept_word(bad[i]);
            chk($sformatf("bad%0d illegal", i), 32'(bus.illegal), 32'h1);
            chk($sformatf("bad%0d enables", i), 32'(en_now()), 32'(E_NONE));
            chk($sformatf("bad%0d imm_valid", i), 32'(bus.imm_valid), 32'h0);
            chk($sformatf("bad%0d halted", i), 32'(bus.halted), 32'h1);
            bus.out_ready = 1'b1;
            #1;
            chk($sformatf("bad%0d instr_ready", i), 32'(bus.instr_ready), 32'h0);
            bus.instr       = 32'hFFF30293;
            bus.instr_valid = 1'b1;
            tick();
            chk($sformatf("bad%0d drained", i), 32'(bus.out_valid), 32'h0);
            chk($sformatf("bad%0d still halted", i), 32'(bus.halted), 32'h1);
            tick();
            chk($sformatf("bad%0d no accept in halt", i), 32'(bus.out_valid), 32'h0);
            bus.instr_valid = 1'b0;
            bus.clear_halt  = 1'b1;
            tick();
            bus.clear_halt  = 1'b0;
            chk($sformatf("bad%0d cleared", i), 32'(bus.halted), 32'h0);
            chk($sformatf("bad%0d ready again", i), 32'(bus.instr_ready), 32'h1);
        end

        // clear_halt in RUN is ignored
        bus.clear_halt = 1'b1;
        accept_word(32'hFFF30293);
        bus.clear_halt = 1'b0;
        chk("run clear halted", 32'(bus.halted), 32'h0);
        chk("run clear enables", 32'(en_now()), 32'(E_ADD));

        // clear_halt coincident with the halting accept: HALT wins
        bus.clear_halt = 1'b1;
        accept_word(32'h0000006F);
        bus.clear_halt = 1'b0;
        chk("coincide halted", 32'(bus.halted), 32'h1);
        chk("coincide illegal", 32'(bus.illegal), 32'h1);
        tick();
        bus.clear_halt = 1'b1;
        tick();
        bus.clear_halt = 1'b0;
        chk("coincide cleared", 32'(bus.halted), 32'h0);

        // Asynchronous reset while an entry is held
        bus.out_ready = 1'b0;
        accept_word(32'hFFF30293);
        chk("pre-reset out_valid", 32'(bus.out_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(bus.out_valid), 32'h0);
        chk("async rst enables", 32'(en_now()), 32'(E_NONE));
        chk("async rst imm", bus.imm, 32'h0);
        chk("async rst sign_valid", 32'(bus.sign_valid), 32'h0);
        bus.instr       = 32'h402081B3;
        bus.instr_valid = 1'b1;
        bus.out_ready   = 1'b1;
        tick();
        chk("in rst no accept", 32'(bus.out_valid), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        chk("post rst accept", 32'(bus.out_valid), 32'h1);
        chk("post rst enables", 32'(en_now()), 32'(E_SUB));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
